// File: rtl/lock_pkg.sv
// Shared types and constants for the code-lock sequencer: state encoding,
// LED bar command values and the digit counter width.
package lock_pkg;

  typedef enum logic [2:0] {
    ENTRY = 3'd0,
    CHECK = 3'd1,
    OPEN  = 3'd2,
    FAIL  = 3'd3,
    ALARM = 3'd4
  } state_t;

  localparam int DIGIT_CNT_W = 3;

  localparam logic [DIGIT_CNT_W-1:0] LED_CMD_0 = 3'd0;
  localparam logic [DIGIT_CNT_W-1:0] LED_CMD_1 = 3'd1;
  localparam logic [DIGIT_CNT_W-1:0] LED_CMD_2 = 3'd2;
  localparam logic [DIGIT_CNT_W-1:0] LED_CMD_3 = 3'd3;
  localparam logic [DIGIT_CNT_W-1:0] LED_CMD_4 = 3'd4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// LED blink generator: while enabled, toggles every HALF cycles starting
// from 0 on the enabling edge; holds the LEDs on (1) while disabled.
module blink_gen #(
  parameter int unsigned HALF = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_blink
);

  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_en_d;
  logic             r_blink;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_en_d  <= 1'b0;
      r_blink <= 1'b1;
    end else begin
      r_en_d <= i_en;
      if (i_en && !r_en_d) begin
        r_cnt   <= RELOAD;
        r_blink <= 1'b0;
      end else if (i_en) begin
        if (r_cnt == '0) begin
          r_cnt   <= RELOAD;
          r_blink <= ~r_blink;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end else begin
        r_cnt   <= '0;
        r_blink <= 1'b1;
      end
    end
  end

  assign o_blink = r_blink;

endmodule

// File: rtl/lock_controller.sv
// Code-lock sequencer: collects four keypad digits, compares them with the
// stored code, tracks consecutive failures and times the OPEN/FAIL/ALARM phases.
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [15:0] CODE          = 16'h1234,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned UNLOCK_CYCLES = 50_000_000,
  parameter int unsigned FAIL_CYCLES   = 25_000_000,
  parameter int unsigned ALARM_CYCLES  = 250_000_000,
  parameter int unsigned BLINK_HALF    = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_clear,
  output logic [2:0] led_cmd,
  output logic       blink,
  output logic       alarm,
  output logic       unlocked
);

  localparam int unsigned MAX_DUR = max3(UNLOCK_CYCLES, FAIL_CYCLES, ALARM_CYCLES);
  localparam int DWELL_W = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
  localparam int FAILS_W = 3;
  localparam logic [FAILS_W-1:0] FAILS_MAX = FAILS_W'(MAX_FAILS);

  state_t                 r_state, w_state_nxt;
  logic [DIGIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]            r_entry, w_entry_nxt;
  logic [FAILS_W-1:0]     r_fails, w_fails_nxt, w_fails_inc;
  logic [DWELL_W-1:0]     r_dwell, w_dwell_nxt;
  logic [2:0]             r_led_cmd, w_led_nxt;
  logic                   r_alarm, r_unlocked;
  logic                   w_blink_en;
  logic                   w_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ENTRY;
      r_cnt      <= '0;
      r_entry    <= '0;
      r_fails    <= '0;
      r_dwell    <= '0;
      r_led_cmd  <= LED_CMD_0;
      r_alarm    <= 1'b0;
      r_unlocked <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_entry    <= w_entry_nxt;
      r_fails    <= w_fails_nxt;
      r_dwell    <= w_dwell_nxt;
      r_led_cmd  <= w_led_nxt;
      r_alarm    <= (w_state_nxt == ALARM);
      r_unlocked <= (w_state_nxt == OPEN);
    end
  end

  assign w_fails_inc = (r_fails == FAILS_MAX) ? r_fails : r_fails + 1'b1;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_entry_nxt = r_entry;
    w_fails_nxt = r_fails;
    w_dwell_nxt = r_dwell;

    case (r_state)
      ENTRY: begin
        // Clear takes priority over a coincident digit.
        if (key_clear) begin
          w_cnt_nxt = '0;
        end else if (key_valid && (key_digit <= 4'd9)) begin
          w_entry_nxt = {r_entry[11:0], key_digit};
          if (r_cnt == LED_CMD_3) begin
            w_cnt_nxt   = LED_CMD_4;
            w_state_nxt = CHECK;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      CHECK: begin
        if (r_entry == CODE) begin
          w_state_nxt = OPEN;
          w_fails_nxt = '0;
          w_dwell_nxt = DWELL_W'(UNLOCK_CYCLES - 1);
        end else begin
          w_fails_nxt = w_fails_inc;
          if (w_fails_inc == FAILS_MAX) begin
            w_state_nxt = ALARM;
            w_dwell_nxt = DWELL_W'(ALARM_CYCLES - 1);
          end else begin
            w_state_nxt = FAIL;
            w_dwell_nxt = DWELL_W'(FAIL_CYCLES - 1);
          end
        end
      end
      OPEN, FAIL, ALARM: begin
        if (r_dwell == '0) begin
          w_state_nxt = ENTRY;
          w_cnt_nxt   = '0;
          if (r_state == ALARM) w_fails_nxt = '0;
        end else begin
          w_dwell_nxt = r_dwell - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ENTRY;
        w_cnt_nxt   = '0;
      end
    endcase

    w_led_nxt = (w_state_nxt == ENTRY) ? w_cnt_nxt : LED_CMD_4;
  end

  // Enable follows the next state so blink is already 0 in the first FAIL/ALARM cycle.
  assign w_blink_en = (w_state_nxt == FAIL) || (w_state_nxt == ALARM);

  blink_gen #(
    .HALF(BLINK_HALF)
  ) u_blink_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_blink_en),
    .o_blink(w_blink)
  );

  assign led_cmd  = r_led_cmd;
  assign blink    = w_blink;
  assign alarm    = r_alarm;
  assign unlocked = r_unlocked;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with scaled timing parameters; outputs
// are sampled 1 ns after each rising edge.
module tb_lock_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_clear = 1'b0;
  logic [2:0] led_cmd;
  logic       blink, alarm, unlocked;

  int n_tests = 0;
  int n_fail  = 0;

  lock_controller #(
    .CODE(16'h1234), .MAX_FAILS(3), .UNLOCK_CYCLES(8), .FAIL_CYCLES(8),
    .ALARM_CYCLES(16), .BLINK_HALF(2)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .led_cmd(led_cmd), .blink(blink), .alarm(alarm),
    .unlocked(unlocked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_digit = 4'd0;
  endtask

  task automatic clear_key();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  // Enters four digits; LED bar follows each accepted digit, CHECK shows 4.
  task automatic enter4(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      key(code[15-4*i -: 4]);
      check("led_step", led_cmd, i + 1);
    end
    check("check_locked", unlocked, 0);
  endtask

  // Eight OPEN cycles, then ENTRY with an empty LED bar.
  task automatic expect_open(input bit press);
    for (int i = 0; i < 8; i++) begin
      if (press && i < 3) key(4'(i + 5)); else tick();
      check("open_unlocked", unlocked, 1);
      check("open_led", led_cmd, 4);
      check("open_blink", blink, 1);
    end
    tick();
    check("open_end_unlocked", unlocked, 0);
    check("open_end_led", led_cmd, 0);
  endtask

  // Eight FAIL cycles with blink 0,0,1,1,..., then ENTRY with blink on.
  task automatic expect_fail(input bit press);
    for (int i = 0; i < 8; i++) begin
      if (press && i < 3) key(4'(i + 1)); else tick();
      check("fail_blink", blink, (i >> 1) & 1);
      check("fail_alarm", alarm, 0);
      check("fail_led", led_cmd, 4);
      check("fail_unlocked", unlocked, 0);
    end
    tick();
    check("fail_end_led", led_cmd, 0);
    check("fail_end_blink", blink, 1);
  endtask

  task automatic expect_alarm(input bit press);
    for (int i = 0; i < 16; i++) begin
      if (press && i < 3) key(4'(i + 1)); else tick();
      check("alarm_on", alarm, 1);
      check("alarm_blink", blink, (i >> 1) & 1);
      check("alarm_led", led_cmd, 4);
    end
    tick();
    check("alarm_end", alarm, 0);
    check("alarm_end_blink", blink, 1);
    check("alarm_end_led", led_cmd, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_led", led_cmd, 0);
    check("rst_blink", blink, 1);
    check("rst_alarm", alarm, 0);
    check("rst_unlocked", unlocked, 0);

    // Correct entry
    enter4(16'h1234);
    expect_open(1'b0);

    // Clear handling
    key(4'd1); key(4'd2);
    check("pre_clear_led", led_cmd, 2);
    clear_key();
    check("clear_led", led_cmd, 0);
    enter4(16'h1234);
    expect_open(1'b0);

    // Clear coincident with a digit: the digit is dropped
    key(4'd1);
    check("pre_coinc_led", led_cmd, 1);
    key_clear = 1'b1; key_valid = 1'b1; key_digit = 4'd2;
    tick();
    key_clear = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    check("coinc_led", led_cmd, 0);
    enter4(16'h1234);
    expect_open(1'b0);

    // Wrong code x3 -> alarm (keys during alarm ignored), then correct opens
    enter4(16'h1235); expect_fail(1'b0);
    enter4(16'h1235); expect_fail(1'b0);
    enter4(16'h1235); expect_alarm(1'b1);
    key(4'd1);
    check("post_alarm_cnt", led_cmd, 1);
    clear_key();
    enter4(16'h1234);
    expect_open(1'b0);

    // Correct code in the middle clears the fail count
    enter4(16'h1235); expect_fail(1'b0);
    enter4(16'h1235); expect_fail(1'b0);
    enter4(16'h1234); expect_open(1'b0);
    enter4(16'h1235); expect_fail(1'b0);
    enter4(16'h1235); expect_fail(1'b0);

    // Digits 10..15 ignored in ENTRY
    for (int d = 10; d < 16; d++) begin
      key(4'(d));
      check("hex_ignored_0", led_cmd, 0);
    end
    key(4'd1); key(4'd2);
    for (int d = 10; d < 16; d++) begin
      key(4'(d));
      check("hex_ignored_2", led_cmd, 2);
    end
    key(4'd3); key(4'd4);
    check("hex_then_4", led_cmd, 4);
    expect_open(1'b1);
    key(4'd1);
    check("post_open_cnt", led_cmd, 1);
    clear_key();

    enter4(16'h1235); expect_fail(1'b1);
    key(4'd1);
    check("post_fail_cnt", led_cmd, 1);
    clear_key();
    enter4(16'h1234); expect_open(1'b0);

    // Reset in ALARM cycle 5, with a key pressed alongside
    enter4(16'h1235); expect_fail(1'b0);
    enter4(16'h1235); expect_fail(1'b0);
    enter4(16'h1235);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pre_rst_alarm", alarm, 1);
    end
    rst = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
    tick();
    rst = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    check("midrst_alarm", alarm, 0);
    check("midrst_blink", blink, 1);
    check("midrst_led", led_cmd, 0);
    check("midrst_unlocked", unlocked, 0);
    enter4(16'h1235); expect_fail(1'b0);
    enter4(16'h1235); expect_fail(1'b0);

    // Reset mid-OPEN closes the lock
    enter4(16'h1234);
    tick(); tick();
    check("pre_rst_open", unlocked, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("open_rst_unlocked", unlocked, 0);
    check("open_rst_led", led_cmd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
# lock_controller

Sequencing FSM for the code-lock project. It collects keypad digits, compares a 4-digit entry against a stored code, and counts failed attempts. Its registered outputs drive the LED bar driver directly:
- `led_cmd`: number of digits entered.
- `blink`: LED gate.
- `alarm`: alarm LED request.
- `unlocked`: to the lock actuator.

It sits between the keypad decoder and the LED driver.

## Interface
- `CODE`, default 16'h1234: stored code, 4 BCD digits, MS nibble entered first.
- `MAX_FAILS`, default 3: consecutive wrong codes that trigger ALARM (1..7).
- `UNLOCK_CYCLES`, default 50_000_000: OPEN duration in clk cycles.
- `FAIL_CYCLES`, default 25_000_000: FAIL indication duration.
- `ALARM_CYCLES`, default 250_000_000: ALARM duration.
- `BLINK_HALF`, default 12_500_000: blink half-period in FAIL/ALARM.

Ports:
- `clk` in 1: system clock, the only clock in the block.
- `rst` in 1: synchronous, active-high reset.
- `key_valid` in 1: one-cycle pulse; `key_digit` is valid in the same cycle.
- `key_digit` in 4: digit value 0..9. Values 10..15 are ignored.
- `key_clear` in 1: one-cycle pulse that discards a partial entry.
- `led_cmd` out 3: LED bar command, 0..4 digits shown.
- `blink` out 1: LED gate; 1 = LEDs on.
- `alarm` out 1: alarm LED request.
- `unlocked` out 1: lock open.

## Operation
- All outputs are registered.
- Reset values: state=ENTRY, digit count=0, fail count=0, `led_cmd`=0, `blink`=1, `alarm`=0, `unlocked`=0.
- ENTRY:
  - `blink`=1 steady; `led_cmd`=digit count.
  - A `key_valid` with digit ≤9 shifts the digit into a 16-bit entry register (left shift by 4) and increments the count.
  - On the 4th accepted digit: go to CHECK, `led_cmd`=4.
  - `key_clear` sets count=0 and `led_cmd`=0, and is not counted as a failure. If `key_clear` and `key_valid` arrive in the same cycle, clear wins and the digit is dropped.
- CHECK lasts exactly 1 cycle:
  - entry==CODE: go to OPEN and clear the fail count.
  - Otherwise increment the fail count. If the new value == `MAX_FAILS`, go to ALARM; else go to FAIL.
- OPEN: `unlocked`=1, `led_cmd`=4, `blink`=1. After `UNLOCK_CYCLES` cycles: go to ENTRY, count=0, `led_cmd`=0, `unlocked`=0.
- FAIL: `led_cmd`=4; `blink` toggles every `BLINK_HALF` cycles, starting at 0 on entry. After `FAIL_CYCLES`: go to ENTRY, count=0, `blink`=1.
- ALARM: `alarm`=1, `led_cmd`=4, `blink` toggles as in FAIL. After `ALARM_CYCLES`: go to ENTRY, fail count=0, `alarm`=0, `blink`=1.
- `key_valid` and `key_clear` are ignored in CHECK, OPEN, FAIL and ALARM. No queuing.
- Fail count saturates at `MAX_FAILS`. It is cleared only by a correct code, the end of ALARM, or `rst`.
- Dwell counter:
  - One shared down-counter, wide enough for the largest duration parameter.
  - Loaded on state entry with duration−1; the state exits when it reads 0.
- `led_cmd` never exceeds 4; encodings 5..7 are never driven.

## Timing
- `key_valid` at cycle t (ENTRY): `led_cmd` updates at t+1.
- 4th digit at t: CHECK at t+1 (`led_cmd`=4); OPEN, FAIL or ALARM outputs visible at t+2.
- OPEN, FAIL and ALARM each last exactly their parameter's number of cycles. ENTRY outputs appear on the following cycle.
- First `blink` toggle in FAIL/ALARM comes `BLINK_HALF` cycles after the state is entered.
- `rst` asserted in any state: reset values at the next edge, regardless of other inputs. This includes mid-ALARM (alarm drops) and mid-OPEN (lock closes).

## Structure
- Package `lock_pkg`:
  - State encoding: ENTRY, CHECK, OPEN, FAIL, ALARM.
  - LED command constants `LED_CMD_0`..`LED_CMD_4`.
  - Digit count width.
- Sub-module `blink_gen`:
  - Enable-gated half-period counter plus toggle flip-flop.
  - Reloads and forces output 0 when enable rises; outputs 1 when disabled.
  - Instantiated once.

## Test plan
Scaled parameters: `CODE`=16'h1234, `MAX_FAILS`=3, `UNLOCK_CYCLES`=8, `FAIL_CYCLES`=8, `ALARM_CYCLES`=16, `BLINK_HALF`=2.

- Correct entry: keys 1,2,3,4.
  - `led_cmd` steps 1,2,3,4, one cycle after each key.
  - `unlocked`=1 two cycles after key 4, held 8 cycles, then `led_cmd`=0.
- Clear handling: keys 1,2, then `key_clear`, then 1,2,3,4.
  - `led_cmd` goes to 0 after the clear, then the lock opens.
  - Repeat with `key_clear` coincident with a digit: the digit is dropped.
- Wrong code ×3: enter 1,2,3,5 three times.
  - First two attempts: FAIL with `blink` pattern 0,0,1,1,0,0,1,1, `alarm`=0.
  - Third attempt: `alarm`=1 for 16 cycles, then fail count=0.
  - A following correct code opens the lock.
- Fail counter reset: wrong, wrong, correct, wrong, wrong.
  - No alarm, because the correct code cleared the count.
- Ignored input:
  - Digits 10..15 in ENTRY do not change `led_cmd`.
  - Keys pressed during OPEN, FAIL and ALARM do not change the digit count after return to ENTRY.
- Reset mid-operation: `rst` asserted in cycle 5 of ALARM.
  - Next cycle: `alarm`=0, `blink`=1, `led_cmd`=0, `unlocked`=0.
  - Two wrong codes afterwards give no alarm.
